// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store initiator between execute and the word-wide
// data memory. Handles byte/half/word loads with sign/zero extension and
// sub-word stores as read-modify-write, since the memory has no byte enables.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned requests
// are trapped to ERR and pulse err; when undefined they are aligned down.
module lsu_dmem_master #(
    parameter bit MEM_WORD_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        st_done,
    output logic        err,
    output logic        mem_dmem,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_w,
    input  logic [31:0] mem_data_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_ERR      = 3'd4;

    logic [2:0]  state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic [31:0] al_addr;
    logic [31:0] mem_addr_next;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic        trap;

    // Memory only writes in WRITE; every other state (including reset) reads.
    assign req_ready = (state == S_IDLE);
    assign mem_dmem  = (state != S_WRITE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((req_size == 2'b01) && req_addr[0]) ||
                  (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
    assign err  = 1'b0;
`endif

    // Align the request address down to its access size.
    always_comb begin
        // NOTE: default assignment first so no path leaves al_addr unassigned (no latch).
        al_addr = req_addr;
        if (req_size == 2'b01)
            al_addr[0] = 1'b0;
        else if (req_size[1])
            al_addr[1:0] = 2'b00;
    end

    assign mem_addr_next = MEM_WORD_ADDR ? {2'b00, al_addr[31:2]}
                                         : {al_addr[31:2], 2'b00};

    // Extract the addressed lane of the read word and extend it.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = mem_data_o[{lane_q, 3'b000} +: 8];
        h = lane_q[1] ? mem_data_o[31:16] : mem_data_o[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & b[7]}}, b};
            2'b01:   load_ext = {{16{~uns_q & h[15]}}, h};
            default: load_ext = mem_data_o;
        endcase
    end

    // Merge store data into the read word, leaving other bytes untouched.
    always_comb begin
        merged = mem_data_o;
        case (size_q)
            2'b00: merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (lane_q[1])
                    merged[31:16] = wdata_q[15:0];
                else
                    merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // Request capture, FSM sequencing and registered memory/response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            mem_addr   <= '0;
            mem_data_w <= '0;
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
            st_done    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking for all state so every register sees pre-edge values.
            rsp_valid <= 1'b0;
            st_done   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err       <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        lane_q  <= al_addr[1:0];
                        wdata_q <= req_wdata;
                        if (trap) begin
                            state <= S_ERR;
                        end else begin
                            mem_addr <= mem_addr_next;
                            if (req_we && req_size[1]) begin
                                mem_data_w <= req_wdata;
                                state      <= S_WRITE;
                            end else begin
                                state <= S_RD_ISSUE;
                            end
                        end
                    end
                end
                S_RD_ISSUE: state <= S_RD_DATA;
                S_RD_DATA: begin
                    if (we_q) begin
                        mem_data_w <= merged;
                        state      <= S_WRITE;
                    end else begin
                        rsp_data  <= load_ext;
                        rsp_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    st_done <= 1'b1;
                    state   <= S_IDLE;
                end
                S_ERR: begin
`ifdef LSU_MISALIGN_TRAP_EN
                    err <= 1'b1;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store initiator between the execute stage and the data memory stage (`mem`).
- Accepts one load/store request at a time from the pipeline and drives the memory's `dmem`/`addr`/`data_w` interface. It consumes the memory's registered `data_o`.
- Handles byte/halfword/word accesses with sign/zero extension, and does sub-word stores as read-modify-write, because the memory is word-wide with no byte enables.
- Returns load data and completion/error pulses to the pipeline.

Parameters:
- `MEM_WORD_ADDR`, default 1: 1 → `mem_addr = {2'b00, byte_addr[31:2]}` (word index); 0 → `mem_addr = {byte_addr[31:2], 2'b00}`.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request (high only in IDLE)
- `req_we`  in  1  1=store, 0=load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `rsp_valid`  out  1  one-cycle pulse, `rsp_data` valid
- `rsp_data`  out  32  extended load result, held until next load
- `st_done`  out  1  one-cycle pulse when a store's memory write has been issued
- `err`  out  1  one-cycle misalignment pulse (only with feature enabled)
- `mem_dmem`  out  1  to memory: 1=read, 0=write
- `mem_addr`  out  32  to memory address
- `mem_data_w`  out  32  to memory write data
- `mem_data_o`  in  32  from memory, registered; valid the cycle after a read is presented

Behaviour:
- Accept on a rising edge when `req_valid && req_ready`; all request fields are captured into registers then. Memory-side outputs are driven only from registered state/request.
- Memory write is combinational in the responder whenever `mem_dmem=0`, so `mem_dmem` is 0 only in state WRITE and 1 in every other state.
- FSM states: IDLE, RD_ISSUE, RD_DATA, WRITE, ERR.
  - IDLE → WRITE: word store.
  - IDLE → RD_ISSUE: load or sub-word store.
  - RD_ISSUE → RD_DATA (always).
  - RD_DATA → IDLE: load; `rsp_data` is captured at the RD_DATA edge and `rsp_valid` pulses in the following IDLE cycle.
  - RD_DATA → WRITE: sub-word store; the merged word is captured into the `mem_data_w` register.
  - WRITE → IDLE; `st_done` pulses in the following IDLE cycle.
  - IDLE → ERR → IDLE: misaligned request with feature enabled; `err` pulses in the IDLE cycle after ERR.
- Latency, with acceptance at the edge ending cycle T:
  - load: RD_ISSUE at T+1, RD_DATA at T+2, `rsp_valid` at T+3.
  - word store: WRITE at T+1, `st_done` at T+2.
  - sub-word store: WRITE at T+3, `st_done` at T+4.
  - `req_ready` is high again in the same cycle as the pulse, so back-to-back acceptance is allowed there.
- Lane select, little-endian:
  - byte lane = `addr[1:0]`, half lane = `addr[1]`.
  - Load extract: shift the lane to bits [7:0]/[15:0], then sign- or zero-extend per `req_unsigned`.
  - Store merge: replace only the addressed byte/half of the read word with `req_wdata[7:0]`/`[15:0]`; other bytes unchanged.
- Misaligned: half with `addr[0]=1`; word with `addr[1:0]!=0`.
- Reset (async, `rst` low):
  - state → IDLE; `mem_dmem` = 1 immediately, so a WRITE in progress is aborted with no write.
  - `mem_addr`, `mem_data_w`, `rsp_data` = 0; `rsp_valid`, `st_done`, `err` = 0.
  - `req_valid` is ignored while `rst` is low.
- `req_valid` deasserting while not ready has no effect; no request is ever queued.

Optional Feature:
- `LSU_MISALIGN_TRAP_EN`
  - Defined: a misaligned request is accepted, goes to ERR with no memory access (`mem_dmem` stays 1), and pulses `err`. No `rsp_valid`/`st_done` is produced.
  - Undefined: `err` is tied 0, and misaligned addresses are aligned down (half: `addr[0]` forced 0; word: `addr[1:0]` forced 00) and processed normally.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10:
  - store: `mem_dmem=0`, `mem_addr=0x4` for exactly one cycle, `st_done` at T+2.
  - load: `rsp_valid` at T+3 with `rsp_data=0xDEADBEEF`.
- Byte load `addr=0x13` from word 0x80FF1234:
  - signed → `rsp_data=0xFFFFFF80`.
  - unsigned → `0x00000080`.
- Half store 0xAAAA @0x12 over word 0x11223344:
  - one read cycle, then write of 0xAAAA3344.
  - `mem_dmem=0` only in the WRITE cycle; `st_done` at T+4.
- Half load @0x11:
  - with `LSU_MISALIGN_TRAP_EN`: `err` pulse, `mem_dmem` stays 1, no `rsp_valid`.
  - without: reads half at 0x10.
- Assert `rst` low during WRITE of a sub-word store:
  - `mem_dmem` goes 1 immediately and all outputs return to reset values.
  - `req_ready=1` after release; the next load completes normally.
- Back-to-back load then store with `req_valid` held high:
  - the second request is accepted in the `rsp_valid` cycle of the first, with no idle gap.
